// File: rtl/fifo_port32_pkg.sv
// Shared constants and types for the 32-bit FIFO port blocks.
package fifo_port32_pkg;

    localparam int unsigned FP_DATA_W = 32;
    localparam int unsigned FP_TAG_W  = 16;
    localparam int unsigned FP_NUM_CH = 4;
    localparam int unsigned FP_DEPTH  = 16;

    localparam int unsigned FP_ERR_OVF = 0;
    localparam int unsigned FP_ERR_UNF = 1;

    typedef struct packed {
        logic [FP_DATA_W-1:0] data;
        logic [FP_TAG_W-1:0]  tag;
    } fp_entry_t;

endpackage

// File: rtl/fifo_port32_in_chan.sv
// One inbound channel: circular buffer with FWFT head, occupancy count and sticky errors.
module fifo_port32_in_chan
    import fifo_port32_pkg::*;
#(
    parameter int unsigned DATA_W = FP_DATA_W,
    parameter int unsigned TAG_W  = FP_TAG_W,
    parameter int unsigned DEPTH  = FP_DEPTH,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic              rd,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic [DATA_W-1:0] rd_data,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [1:0]        err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned ENT_W = DATA_W + TAG_W;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [ENT_W-1:0] head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       err_q;
    logic             push_ok;
    logic             pop_ok;

    // Flags come only from the registered count, so back-pressure has no path from rd.
    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign push_ok = wr & ~full;
    assign pop_ok  = rd & ~empty;
    assign count   = cnt_q;
    assign err     = err_q;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage carries no reset; stale entries are hidden by the empty gate.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {wr_data, wr_tag};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            err_q  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            cnt_q <= cnt_d;
            err_q[FP_ERR_OVF] <= err_q[FP_ERR_OVF] | (wr & full);
            err_q[FP_ERR_UNF] <= err_q[FP_ERR_UNF] | (rd & empty);
        end
    end

    assign head    = mem[rd_ptr];
    assign rd_data = empty ? '0 : head[ENT_W-1 -: DATA_W];
    assign rd_tag  = empty ? '0 : head[TAG_W-1:0];

endmodule

// File: rtl/fifo_port32_in.sv
// Inbound FIFO port: NUM_CH independent accelerator-to-agent channels on packed ports.
module fifo_port32_in
    import fifo_port32_pkg::*;
#(
    parameter int unsigned NUM_CH = FP_NUM_CH,
    parameter int unsigned DATA_W = FP_DATA_W,
    parameter int unsigned TAG_W  = FP_TAG_W,
    parameter int unsigned DEPTH  = FP_DEPTH,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        acc_wr,
    input  logic [NUM_CH*DATA_W-1:0] fpi_data,
    input  logic [NUM_CH*TAG_W-1:0]  fpi_ptag,
    output logic [NUM_CH-1:0]        fpi_full,
    output logic [NUM_CH*CNT_W-1:0]  fpi_full_count,
    input  logic [NUM_CH-1:0]        fp_infifo_read,
    output logic [NUM_CH*DATA_W-1:0] fp_infifo_data,
    output logic [NUM_CH*TAG_W-1:0]  fp_infifo_pkt_tag,
    output logic [NUM_CH-1:0]        fp_infifo_empty,
    output logic [NUM_CH*2-1:0]      fpi_err
);

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        fifo_port32_in_chan #(
            .DATA_W (DATA_W),
            .TAG_W  (TAG_W),
            .DEPTH  (DEPTH),
            .CNT_W  (CNT_W)
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .wr      (acc_wr[n]),
            .wr_data (fpi_data[n*DATA_W +: DATA_W]),
            .wr_tag  (fpi_ptag[n*TAG_W +: TAG_W]),
            .rd      (fp_infifo_read[n]),
            .full    (fpi_full[n]),
            .count   (fpi_full_count[n*CNT_W +: CNT_W]),
            .empty   (fp_infifo_empty[n]),
            .rd_data (fp_infifo_data[n*DATA_W +: DATA_W]),
            .rd_tag  (fp_infifo_pkt_tag[n*TAG_W +: TAG_W]),
            .err     (fpi_err[n*2 +: 2])
        );
    end

endmodule

// File: tb/tb_fifo_port32_in.sv
// Directed bench for fifo_port32_in with a per-channel queue scoreboard.
module tb_fifo_port32_in;
    import fifo_port32_pkg::*;

    logic          clk;
    logic          reset_n;
    logic [3:0]    acc_wr;
    logic [127:0]  fpi_data;
    logic [63:0]   fpi_ptag;
    logic [3:0]    fpi_full;
    logic [19:0]   fpi_full_count;
    logic [3:0]    fp_infifo_read;
    logic [127:0]  fp_infifo_data;
    logic [63:0]   fp_infifo_pkt_tag;
    logic [3:0]    fp_infifo_empty;
    logic [7:0]    fpi_err;

    int checks = 0;
    int errors = 0;

    fp_entry_t   sb [4][$];
    logic [1:0]  err_m [4];
    logic [31:0] pd [4];
    logic [15:0] pt [4];

    fifo_port32_in dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .acc_wr            (acc_wr),
        .fpi_data          (fpi_data),
        .fpi_ptag          (fpi_ptag),
        .fpi_full          (fpi_full),
        .fpi_full_count    (fpi_full_count),
        .fp_infifo_read    (fp_infifo_read),
        .fp_infifo_data    (fp_infifo_data),
        .fp_infifo_pkt_tag (fp_infifo_pkt_tag),
        .fp_infifo_empty   (fp_infifo_empty),
        .fpi_err           (fpi_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int ch, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s ch%0d got=%h exp=%h", tag, ch, got, exp);
        end
    endtask

    task automatic check_all();
        int n;
        logic [31:0] ed;
        logic [15:0] et;
        for (int ch = 0; ch < 4; ch++) begin
            n  = sb[ch].size();
            ed = (n > 0) ? sb[ch][0].data : 32'h0;
            et = (n > 0) ? sb[ch][0].tag  : 16'h0;
            chk("data",  ch, fp_infifo_data[ch*32 +: 32], ed);
            chk("tag",   ch, 32'(fp_infifo_pkt_tag[ch*16 +: 16]), 32'(et));
            chk("count", ch, 32'(fpi_full_count[ch*5 +: 5]), 32'(n));
            chk("empty", ch, 32'(fp_infifo_empty[ch]), 32'(n == 0));
            chk("full",  ch, 32'(fpi_full[ch]), 32'(n == 16));
            chk("err",   ch, 32'(fpi_err[ch*2 +: 2]), 32'(err_m[ch]));
        end
    endtask

    // Update the model with what the DUT should accept on the coming edge, then clock.
    task automatic do_cycle(input logic [3:0] wr, input logic [3:0] rd);
        fp_entry_t e;
        bit full_m;
        bit empty_m;
        acc_wr = wr;
        fp_infifo_read = rd;
        for (int ch = 0; ch < 4; ch++) begin
            fpi_data[ch*32 +: 32] = pd[ch];
            fpi_ptag[ch*16 +: 16] = pt[ch];
            full_m  = (sb[ch].size() == 16);
            empty_m = (sb[ch].size() == 0);
            if (rd[ch]) begin
                if (empty_m) err_m[ch][1] = 1'b1;
                else void'(sb[ch].pop_front());
            end
            if (wr[ch]) begin
                if (full_m) err_m[ch][0] = 1'b1;
                else begin
                    e.data = pd[ch];
                    e.tag  = pt[ch];
                    sb[ch].push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
        acc_wr = '0;
        fp_infifo_read = '0;
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < 4; ch++) begin
            sb[ch].delete();
            err_m[ch] = 2'b00;
        end
    endtask

    initial begin
        logic [3:0] w;
        logic [3:0] r;
        reset_n = 1'b0;
        acc_wr = '0;
        fp_infifo_read = '0;
        fpi_data = '0;
        fpi_ptag = '0;
        for (int ch = 0; ch < 4; ch++) begin
            pd[ch] = '0;
            pt[ch] = '0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_all();

        // Single push on ch0
        pd[0] = 32'hA5A50001;
        pt[0] = 16'h0011;
        do_cycle(4'b0001, 4'b0000);
        check_all();

        // Fill ch2, overflow, then drain in order
        for (int i = 0; i < 16; i++) begin
            pd[2] = 32'(i);
            pt[2] = 16'(i);
            do_cycle(4'b0100, 4'b0000);
        end
        check_all();
        pd[2] = 32'hDEAD0099;
        pt[2] = 16'h0099;
        do_cycle(4'b0100, 4'b0000);
        check_all();
        for (int i = 0; i < 16; i++) begin
            do_cycle(4'b0000, 4'b0100);
            check_all();
        end

        // ch1: three entries, then simultaneous push/pop across the pointer wrap
        for (int i = 0; i < 3; i++) begin
            pd[1] = 32'h1000_0000 + 32'(i);
            pt[1] = 16'h0100 + 16'(i);
            do_cycle(4'b0010, 4'b0000);
        end
        check_all();
        for (int i = 0; i < 20; i++) begin
            pd[1] = $urandom;
            pt[1] = 16'($urandom);
            do_cycle(4'b0010, 4'b0010);
            check_all();
        end
        for (int i = 0; i < 20; i++) begin
            pd[1] = $urandom;
            pt[1] = 16'($urandom);
            w = {2'b00, 1'($urandom_range(0, 1)), 1'b0};
            r = {2'b00, 1'($urandom_range(0, 1)), 1'b0};
            do_cycle(w, r);
            check_all();
        end

        // ch3: pop and push together while empty
        pd[3] = 32'h12345678;
        pt[3] = 16'h3333;
        do_cycle(4'b1000, 4'b1000);
        check_all();

        // Bring every channel to 8 entries
        for (int k = 0; k < 40; k++) begin
            w = '0;
            r = '0;
            for (int ch = 0; ch < 4; ch++) begin
                pd[ch] = $urandom;
                pt[ch] = 16'($urandom);
                if (sb[ch].size() < 8) w[ch] = 1'b1;
                else if (sb[ch].size() > 8) r[ch] = 1'b1;
            end
            if (w == '0 && r == '0) break;
            do_cycle(w, r);
            check_all();
        end
        for (int ch = 0; ch < 4; ch++) chk("half", ch, 32'(fpi_full_count[ch*5 +: 5]), 32'd8);

        // Asynchronous reset between edges
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_all();

        pd[0] = 32'hCAFEF00D;
        pt[0] = 16'h00C0;
        pd[2] = 32'h0BADBEEF;
        pt[2] = 16'h02B0;
        do_cycle(4'b0101, 4'b0000);
        check_all();
        do_cycle(4'b0000, 4'b0101);
        check_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
